// File: rtl/ula_pkg.sv
// Shared definitions for the expression-solver arithmetic unit.
// Contents: default datapath width and the operation-select encoding.
// Imported by the interface, the multiplier and the ula_core top.
package ula_pkg;

  // Operand and result width used throughout the solver datapath.
  localparam int ULA_WIDTH = 16;

  // Encoding of the 1-bit operation select carried on h.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } op_e;

endpackage : ula_pkg

// File: rtl/ula_if.sv
// Operand/result bundle between the solver stack logic and the ULA.
// Ports: h/a/b/in_valid flow from the operand source to the unit;
//        result/out_valid/overflow flow back to the result register file.
interface ula_if
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
);

  logic             h;          // operation select (op_e encoding)
  logic [WIDTH-1:0] a;          // operand A, unsigned
  logic [WIDTH-1:0] b;          // operand B, unsigned
  logic             in_valid;   // operands/h valid this cycle
  logic [WIDTH-1:0] result;     // registered low WIDTH bits of a op b
  logic             out_valid;  // result written by the previous accepted op
  logic             overflow;   // result was truncated

  // Operand source side (stack logic, testbench).
  modport master (
    output h,
    output a,
    output b,
    output in_valid,
    input  result,
    input  out_valid,
    input  overflow
  );

  // Arithmetic unit side.
  modport slave (
    input  h,
    input  a,
    input  b,
    input  in_valid,
    output result,
    output out_valid,
    output overflow
  );

endinterface : ula_if

// File: rtl/ula_mul.sv
// Purpose: combinational unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.
// Latency: 0 cycles (purely combinational, feeds the ULA output register).
// Backpressure: none; output follows the inputs continuously.
// Ports: a, b (WIDTH, unsigned) in; p (2*WIDTH, full product) out.
module ula_mul
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  // a zero-extended to product width so every shifted partial product fits.
  logic [2*WIDTH-1:0] a_ext;
  // acc[i] holds the sum of the partial products for multiplier bits below i.
  logic [2*WIDTH-1:0] acc [WIDTH+1];

  assign a_ext  = {{WIDTH{1'b0}}, a};
  assign acc[0] = '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    logic [2*WIDTH-1:0] pp;
    // Partial product for bit i of b: a shifted into position, or nothing.
    assign pp         = b[i] ? (a_ext << i) : '0;
    assign acc[i + 1] = acc[i] + pp;
  end : g_pp

  // The full 2*WIDTH sum cannot wrap: max product is (2^W-1)^2 < 2^(2W).
  assign p = acc[WIDTH];

endmodule : ula_mul

// File: rtl/ula_core.sv
// Purpose: registered add/multiply unit for the solver; result = low WIDTH bits of a op b.
// Latency: 1 cycle from accepted operands to result/out_valid, 1 op per cycle.
// Backpressure: none; every in_valid cycle is accepted, nothing stalls.
// Ports: clk, rst (sync, active-high) plain; bus (ula_if.slave) carries
//        h/a/b/in_valid in and result/out_valid/overflow out.
module ula_core
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  ula_if.slave  bus
);

  // One extra bit on the sum captures the carry-out used as overflow.
  logic [WIDTH:0]     sum_full;
  logic [2*WIDTH-1:0] prod_full;

  // Next-state values for the output register, selected by h.
  logic [WIDTH-1:0]   result_d;
  logic               overflow_d;

  logic [WIDTH-1:0]   result_q;
  logic               overflow_q;
  logic               out_valid_q;

  // ---------------------------------------------------------------------------
  // Datapath: adder inline, multiplier as a separate combinational block.
  // ---------------------------------------------------------------------------
  assign sum_full = {1'b0, bus.a} + {1'b0, bus.b};

  ula_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .a (bus.a),
    .b (bus.b),
    .p (prod_full)
  );

  // Operation mux and overflow select. Add is the default branch so an
  // undriven h only ever steers a value that is discarded when in_valid=0.
  always_comb begin
    result_d   = sum_full[WIDTH-1:0];
    overflow_d = sum_full[WIDTH];
    if (bus.h == OP_MUL) begin
      result_d   = prod_full[WIDTH-1:0];
      // Any set bit above the kept half means the product was truncated.
      overflow_d = |prod_full[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Single output register stage.
  // result/overflow load only on an accepted op, so operand values seen while
  // in_valid=0 (possibly X) never reach the outputs; they simply hold.
  // Reset takes priority over a coincident accept, dropping that operation.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_q;

endmodule : ula_core

// File: tb/tb_ula_core.sv
// Directed self-checking bench for ula_core (WIDTH = 16).
// Each task drives one scenario and compares {out_valid, overflow, result}
// against hand-computed values one clock after the operands are presented.
module tb_ula_core;

  localparam int W = 16;

  logic clk;
  logic rst;

  int tests;
  int fails;

  ula_if #(.WIDTH(W)) bus ();

  ula_core #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present inputs mid-cycle (negedge), then advance through the next posedge
  // and settle 1 time unit so outputs are sampled away from the active edge.
  task automatic drive(input logic r, input logic v, input logic hh,
                       input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.h        = hh;
    bus.a        = aa;
    bus.b        = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0003);
      tests++;
      if ({bus.out_valid, bus.overflow, bus.result} !== {1'b0, 1'b0, 16'h0000}) begin
        fails++;
        $display("FAIL reset_%0d: got v=%b ovf=%b res=%h, want v=0 ovf=0 res=0000",
                 i, bus.out_valid, bus.overflow, bus.result);
      end
    end
  endtask

  task automatic test_add();
    drive(1'b0, 1'b1, 1'b0, 16'h0060, 16'h0003);
    tests++;
    if ({bus.out_valid, bus.overflow, bus.result} !== {1'b1, 1'b0, 16'h0063}) begin
      fails++;
      $display("FAIL add: got v=%b ovf=%b res=%h, want v=1 ovf=0 res=0063",
               bus.out_valid, bus.overflow, bus.result);
    end
  endtask

  task automatic test_back_to_back();
    logic          hv [4];
    logic [W-1:0]  av [4];
    logic [W-1:0]  bv [4];
    logic [W-1:0]  ev [4];
    hv[0] = 1'b1; av[0] = 16'h0060; bv[0] = 16'h0003; ev[0] = 16'h0120;
    hv[1] = 1'b0; av[1] = 16'h0004; bv[1] = 16'h0003; ev[1] = 16'h0007;
    hv[2] = 1'b1; av[2] = 16'h0004; bv[2] = 16'h0003; ev[2] = 16'h000C;
    hv[3] = 1'b1; av[3] = 16'h1234; bv[3] = 16'h0005; ev[3] = 16'h5B04;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, hv[i], av[i], bv[i]);
      tests++;
      if ({bus.out_valid, bus.overflow, bus.result} !== {1'b1, 1'b0, ev[i]}) begin
        fails++;
        $display("FAIL b2b_%0d: got v=%b ovf=%b res=%h, want v=1 ovf=0 res=%h",
                 i, bus.out_valid, bus.overflow, bus.result, ev[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic          hv [5];
    logic [W-1:0]  av [5];
    logic [W-1:0]  bv [5];
    logic [W-1:0]  ev [5];
    logic          ov [5];
    hv[0] = 1'b0; av[0] = 16'hFFFF; bv[0] = 16'h0001; ev[0] = 16'h0000; ov[0] = 1'b1;
    hv[1] = 1'b1; av[1] = 16'h0100; bv[1] = 16'h0100; ev[1] = 16'h0000; ov[1] = 1'b1;
    hv[2] = 1'b1; av[2] = 16'h00FF; bv[2] = 16'h0101; ev[2] = 16'hFFFF; ov[2] = 1'b0;
    hv[3] = 1'b1; av[3] = 16'hFFFF; bv[3] = 16'hFFFF; ev[3] = 16'h0001; ov[3] = 1'b1;
    hv[4] = 1'b0; av[4] = 16'h8000; bv[4] = 16'h8001; ev[4] = 16'h0001; ov[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, hv[i], av[i], bv[i]);
      tests++;
      if ({bus.out_valid, bus.overflow, bus.result} !== {1'b1, ov[i], ev[i]}) begin
        fails++;
        $display("FAIL ovf_%0d: got v=%b ovf=%b res=%h, want v=1 ovf=%b res=%h",
                 i, bus.out_valid, bus.overflow, bus.result, ov[i], ev[i]);
      end
    end
  endtask

  task automatic test_idle();
    // Known op first, then idle cycles with X operands: values must hold.
    drive(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0101);  // 0x10100 -> res 0100, ovf 1
    tests++;
    if ({bus.out_valid, bus.overflow, bus.result} !== {1'b1, 1'b1, 16'h0100}) begin
      fails++;
      $display("FAIL idle_pre: got v=%b ovf=%b res=%h, want v=1 ovf=1 res=0100",
               bus.out_valid, bus.overflow, bus.result);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'bx, 'x, 'x);
      tests++;
      if ({bus.out_valid, bus.overflow, bus.result} !== {1'b0, 1'b1, 16'h0100}) begin
        fails++;
        $display("FAIL idle_hold_%0d: got v=%b ovf=%b res=%h, want v=0 ovf=1 res=0100",
                 i, bus.out_valid, bus.overflow, bus.result);
      end
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b0, 1'b1, 1'b0, 16'h8000, 16'h8001);  // res 0001, ovf 1
    drive(1'b1, 1'b1, 1'b1, 16'h0003, 16'h0005);
    tests++;
    if ({bus.out_valid, bus.overflow, bus.result} !== {1'b0, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL rst_prio: got v=%b ovf=%b res=%h, want v=0 ovf=0 res=0000",
               bus.out_valid, bus.overflow, bus.result);
    end
    // Discarded op must not surface after reset is released.
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tests++;
    if ({bus.out_valid, bus.overflow, bus.result} !== {1'b0, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL rst_prio_after: got v=%b ovf=%b res=%h, want v=0 ovf=0 res=0000",
               bus.out_valid, bus.overflow, bus.result);
    end
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.h        = 1'b0;
    bus.a        = '0;
    bus.b        = '0;

    test_reset();
    test_add();
    test_back_to_back();
    test_overflow();
    test_idle();
    test_reset_priority();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ula_core
